// File: rtl/dsi_pkg.sv
// Shared definitions for the DSI byte-stream blocks: buffer sizing helpers
// and the byte-count width.
package dsi_pkg;

    localparam int CNT_W = 5;

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Two words of the wider side let a full write and a full pop overlap.
    function automatic int f_buf_bytes(input int in_bytes, input int out_bytes);
        return 2 * f_max(in_bytes, out_bytes);
    endfunction

endpackage

// File: rtl/dsi_unpacker_if.sv
// Word-in / chunk-out bus of the DSI unpacker; signal suffixes are named
// from the unpacker's point of view.
interface dsi_unpacker_if #(
    parameter int g_input_bytes  = 4,
    parameter int g_output_bytes = 3
);
    logic [8*g_input_bytes-1:0]  d_i;
    logic [3:0]                  d_size_i;
    logic                        d_valid_i;
    logic                        d_req_o;
    logic [2:0]                  q_size_i;
    logic                        q_req_i;
    logic [8*g_output_bytes-1:0] q_o;
    logic                        q_valid_o;
    logic                        q_empty_o;
    logic                        flush_i;

    modport slave (
        input  d_i, d_size_i, d_valid_i, q_size_i, q_req_i, flush_i,
        output d_req_o, q_o, q_valid_o, q_empty_o
    );

    modport master (
        output d_i, d_size_i, d_valid_i, q_size_i, q_req_i, flush_i,
        input  d_req_o, q_o, q_valid_o, q_empty_o
    );
endinterface

// File: rtl/dsi_byte_swapper.sv
// Reverses the lowest size_i bytes so the earliest byte lands most significant,
// right-aligned; bytes above the chunk are zero.
module dsi_byte_swapper #(
    parameter int g_num_bytes = 3
) (
    input  logic [8*g_num_bytes-1:0] d_i,
    input  logic [2:0]               size_i,
    output logic [8*g_num_bytes-1:0] q_o
);
    always_comb begin
        q_o = '0;
        for (int i = 0; i < g_num_bytes; i++) begin
            if ((i < 32'(size_i)) && (32'(size_i) <= g_num_bytes)) begin
                q_o[8*(32'(size_i) - 1 - i) +: 8] = d_i[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/dsi_unpacker.sv
// Byte-stream unpacker: buffers packed input words and hands out MSB-first,
// right-aligned chunks of 1..g_output_bytes bytes on request.
module dsi_unpacker
    import dsi_pkg::*;
#(
    parameter int g_input_bytes  = 4,
    parameter int g_output_bytes = 3
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    dsi_unpacker_if.slave bus
);
    localparam int C = f_buf_bytes(g_input_bytes, g_output_bytes);
    localparam logic [CNT_W-1:0] WR_LIMIT = CNT_W'(C - g_input_bytes);

    logic [8*C-1:0]              buf_q, buf_d, buf_s, wr_bytes;
    logic [CNT_W-1:0]            count_q, count_d, count_s;
    logic [8*g_output_bytes-1:0] q_q, q_d, swapped;
    logic                        q_valid_q, q_valid_d;
    logic                        d_req, d_size_ok, q_size_ok, wr_en, pop_en;

    assign d_req     = (count_q <= WR_LIMIT);
    assign d_size_ok = (bus.d_size_i != 4'd0) && (32'(bus.d_size_i) <= g_input_bytes);
    assign q_size_ok = (bus.q_size_i != 3'd0) && (32'(bus.q_size_i) <= g_output_bytes);
    assign wr_en     = bus.d_valid_i && d_req && d_size_ok;
    // Only pre-edge bytes are poppable; same-cycle input is never bypassed.
    assign pop_en    = bus.q_req_i && q_size_ok && (count_q >= CNT_W'(bus.q_size_i));

    dsi_byte_swapper #(
        .g_num_bytes (g_output_bytes)
    ) u_swap (
        .d_i    (buf_q[8*g_output_bytes-1:0]),
        .size_i (bus.q_size_i),
        .q_o    (swapped)
    );

    // Bytes at and above count are kept zero, so appending is a plain OR.
    always_comb begin
        wr_bytes = '0;
        for (int j = 0; j < g_input_bytes; j++) begin
            if (j < 32'(bus.d_size_i)) begin
                wr_bytes[8*j +: 8] = bus.d_i[8*j +: 8];
            end
        end

        buf_s   = buf_q;
        count_s = count_q;
        if (pop_en) begin
            buf_s   = buf_q >> {bus.q_size_i, 3'b000};
            count_s = count_q - CNT_W'(bus.q_size_i);
        end

        buf_d   = buf_s;
        count_d = count_s;
        if (wr_en) begin
            buf_d   = buf_s | (wr_bytes << {count_s, 3'b000});
            count_d = count_s + CNT_W'(bus.d_size_i);
        end

        q_d       = q_q;
        q_valid_d = 1'b0;
        if (pop_en) begin
            q_d       = swapped;
            q_valid_d = 1'b1;
        end

        if (bus.flush_i) begin
            buf_d     = '0;
            count_d   = '0;
            q_d       = q_q;
            q_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_q     <= '0;
            count_q   <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            count_q   <= count_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign bus.d_req_o   = d_req;
    assign bus.q_o       = q_q;
    assign bus.q_valid_o = q_valid_q;
    assign bus.q_empty_o = (count_q == '0);
endmodule

// File: tb/tb_dsi_unpacker.sv
// Directed self-checking bench for dsi_unpacker with 4-byte input words and
// up to 3-byte output chunks (8-byte buffer).
module tb_dsi_unpacker;
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    dsi_unpacker_if #(.g_input_bytes(4), .g_output_bytes(3)) bus ();

    dsi_unpacker #(
        .g_input_bytes  (4),
        .g_output_bytes (3)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input logic [31:0] d, input logic [3:0] sz);
        bus.d_i       = d;
        bus.d_size_i  = sz;
        bus.d_valid_i = 1'b1;
        step();
        bus.d_valid_i = 1'b0;
    endtask

    task automatic do_pop(input logic [2:0] sz);
        bus.q_size_i = sz;
        bus.q_req_i  = 1'b1;
        step();
        bus.q_req_i  = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.q_valid_o, bus.q_o, bus.d_req_o, bus.q_empty_o} !== {1'b0, 24'h0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_initial: valid=%b q=%h req=%b empty=%b, want 0 000000 1 1",
                     bus.q_valid_o, bus.q_o, bus.d_req_o, bus.q_empty_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();
        do_write(32'h44332211, 4'd4);
        do_pop(3'd3);
        n_checks++;
        if ({bus.q_valid_o, bus.q_o} !== {1'b1, 24'h112233}) begin
            n_fail++;
            $display("FAIL reset_prepop: valid=%b q=%h, want 1 112233", bus.q_valid_o, bus.q_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        n_checks++;
        if ({bus.q_valid_o, bus.q_o, bus.d_req_o, bus.q_empty_o} !== {1'b0, 24'h0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b q=%h req=%b empty=%b, want 0 000000 1 1",
                     bus.q_valid_o, bus.q_o, bus.d_req_o, bus.q_empty_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();
        n_checks++;
        if ({bus.q_valid_o, bus.q_empty_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b empty=%b, want 0 1", bus.q_valid_o, bus.q_empty_o);
        end
    endtask

    task automatic test_basic();
        do_write(32'h44332211, 4'd4);
        n_checks++;
        if (bus.q_empty_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_notempty: empty=%b, want 0", bus.q_empty_o);
        end
        do_pop(3'd3);
        n_checks++;
        if ({bus.q_valid_o, bus.q_o} !== {1'b1, 24'h112233}) begin
            n_fail++;
            $display("FAIL basic_pop3: valid=%b q=%h, want 1 112233", bus.q_valid_o, bus.q_o);
        end
        step();
        n_checks++;
        if (bus.q_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse: valid=%b, want 0", bus.q_valid_o);
        end
        do_pop(3'd1);
        n_checks++;
        if ({bus.q_valid_o, bus.q_o, bus.q_empty_o} !== {1'b1, 24'h000044, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_pop1: valid=%b q=%h empty=%b, want 1 000044 1",
                     bus.q_valid_o, bus.q_o, bus.q_empty_o);
        end
    endtask

    task automatic test_fill();
        do_write(32'h44332211, 4'd4);
        n_checks++;
        if (bus.d_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_req4: req=%b, want 1", bus.d_req_o);
        end
        do_write(32'h88776655, 4'd4);
        n_checks++;
        if (bus.d_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_req8: req=%b, want 0", bus.d_req_o);
        end
        do_write(32'hDDCCBBAA, 4'd4);
        do_pop(3'd3);
        n_checks++;
        if ({bus.q_o, bus.d_req_o} !== {24'h112233, 1'b0}) begin
            n_fail++;
            $display("FAIL fill_pop3a: q=%h req=%b, want 112233 0", bus.q_o, bus.d_req_o);
        end
        do_pop(3'd1);
        n_checks++;
        if ({bus.q_o, bus.d_req_o} !== {24'h000044, 1'b1}) begin
            n_fail++;
            $display("FAIL fill_pop1a: q=%h req=%b, want 000044 1", bus.q_o, bus.d_req_o);
        end
        do_pop(3'd3);
        n_checks++;
        if (bus.q_o !== 24'h556677) begin
            n_fail++;
            $display("FAIL fill_pop3b: q=%h, want 556677", bus.q_o);
        end
        do_pop(3'd1);
        n_checks++;
        if ({bus.q_valid_o, bus.q_o, bus.q_empty_o} !== {1'b1, 24'h000088, 1'b1}) begin
            n_fail++;
            $display("FAIL fill_pop1b: valid=%b q=%h empty=%b, want 1 000088 1 (third write must drop)",
                     bus.q_valid_o, bus.q_o, bus.q_empty_o);
        end
    endtask

    task automatic test_simultaneous();
        do_write(32'hA3A2A1A0, 4'd4);
        bus.d_i       = 32'hB3B2B1B0;
        bus.d_size_i  = 4'd4;
        bus.d_valid_i = 1'b1;
        bus.q_size_i  = 3'd3;
        bus.q_req_i   = 1'b1;
        step();
        bus.d_valid_i = 1'b0;
        bus.q_req_i   = 1'b0;
        n_checks++;
        if ({bus.q_valid_o, bus.q_o} !== {1'b1, 24'hA0A1A2}) begin
            n_fail++;
            $display("FAIL simul_pop: valid=%b q=%h, want 1 a0a1a2", bus.q_valid_o, bus.q_o);
        end
        do_pop(3'd3);
        n_checks++;
        if (bus.q_o !== 24'hA3B0B1) begin
            n_fail++;
            $display("FAIL simul_pop3: q=%h, want a3b0b1", bus.q_o);
        end
        do_pop(3'd2);
        n_checks++;
        if ({bus.q_valid_o, bus.q_o, bus.q_empty_o} !== {1'b1, 24'h00B2B3, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_pop2: valid=%b q=%h empty=%b, want 1 00b2b3 1",
                     bus.q_valid_o, bus.q_o, bus.q_empty_o);
        end
    endtask

    task automatic test_invalid_sizes();
        do_write(32'h11111111, 4'd0);
        do_write(32'h22222222, 4'd5);
        n_checks++;
        if (bus.q_empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_dsize: empty=%b, want 1", bus.q_empty_o);
        end
        do_write(32'h00030201, 4'd3);
        do_pop(3'd0);
        n_checks++;
        if (bus.q_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_qsize0: valid=%b, want 0", bus.q_valid_o);
        end
        do_pop(3'd4);
        n_checks++;
        if (bus.q_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_qsize4: valid=%b, want 0", bus.q_valid_o);
        end
        do_pop(3'd3);
        n_checks++;
        if ({bus.q_valid_o, bus.q_o, bus.q_empty_o} !== {1'b1, 24'h010203, 1'b1}) begin
            n_fail++;
            $display("FAIL bad_then_good: valid=%b q=%h empty=%b, want 1 010203 1",
                     bus.q_valid_o, bus.q_o, bus.q_empty_o);
        end
    endtask

    task automatic test_underflow();
        do_write(32'h00000C0B, 4'd2);
        bus.q_size_i = 3'd3;
        bus.q_req_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.q_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL underflow_hold%0d: valid=%b, want 0", i, bus.q_valid_o);
            end
        end
        do_write(32'h0000000D, 4'd1);
        n_checks++;
        if (bus.q_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_edgek: valid=%b, want 0", bus.q_valid_o);
        end
        step();
        bus.q_req_i = 1'b0;
        n_checks++;
        if ({bus.q_valid_o, bus.q_o} !== {1'b1, 24'h0B0C0D}) begin
            n_fail++;
            $display("FAIL underflow_served: valid=%b q=%h, want 1 0b0c0d", bus.q_valid_o, bus.q_o);
        end
        step();
        n_checks++;
        if ({bus.q_valid_o, bus.q_empty_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL underflow_once: valid=%b empty=%b, want 0 1", bus.q_valid_o, bus.q_empty_o);
        end
    endtask

    task automatic test_flush();
        do_write(32'h44332211, 4'd4);
        do_write(32'h00006655, 4'd2);
        bus.flush_i   = 1'b1;
        bus.q_size_i  = 3'd3;
        bus.q_req_i   = 1'b1;
        bus.d_i       = 32'h99999999;
        bus.d_size_i  = 4'd4;
        bus.d_valid_i = 1'b1;
        step();
        bus.flush_i   = 1'b0;
        bus.q_req_i   = 1'b0;
        bus.d_valid_i = 1'b0;
        n_checks++;
        if ({bus.q_valid_o, bus.q_o, bus.q_empty_o, bus.d_req_o} !== {1'b0, 24'h0B0C0D, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL flush: valid=%b q=%h empty=%b req=%b, want 0 0b0c0d 1 1",
                     bus.q_valid_o, bus.q_o, bus.q_empty_o, bus.d_req_o);
        end
        do_write(32'h000000EE, 4'd1);
        do_pop(3'd2);
        n_checks++;
        if (bus.q_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cleared: valid=%b, want 0 (only 1 byte after flush)", bus.q_valid_o);
        end
        do_pop(3'd1);
        n_checks++;
        if ({bus.q_valid_o, bus.q_o} !== {1'b1, 24'h0000EE}) begin
            n_fail++;
            $display("FAIL flush_after: valid=%b q=%h, want 1 0000ee", bus.q_valid_o, bus.q_o);
        end
    endtask

    initial begin
        bus.d_i       = '0;
        bus.d_size_i  = '0;
        bus.d_valid_i = 1'b0;
        bus.q_size_i  = '0;
        bus.q_req_i   = 1'b0;
        bus.flush_i   = 1'b0;
        #12;
        test_reset();
        test_basic();
        test_fill();
        test_simultaneous();
        test_invalid_sizes();
        test_underflow();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
